// File: rtl/trng_health_if.sv
`default_nettype none
// trng_health_if: source, sink and alarm signals of trng_health_ctrl.
// Revision 1.0
interface trng_health_if;
  logic       i_trng_valid;
  logic [7:0] i_trng_dat;
  logic       o_trng_read;
  logic [7:0] o_dat;
  logic       o_valid;
  logic       i_ready;
  logic       i_clear_alarm;
  logic       o_alarm;
  logic [1:0] o_fail_cause;
  logic [1:0] o_state;

  modport slave (
    input  i_trng_valid, i_trng_dat, i_ready, i_clear_alarm,
    output o_trng_read, o_dat, o_valid, o_alarm, o_fail_cause, o_state
  );

  modport master (
    output i_trng_valid, i_trng_dat, i_ready, i_clear_alarm,
    input  o_trng_read, o_dat, o_valid, o_alarm, o_fail_cause, o_state
  );
endinterface
`default_nettype wire

// File: rtl/trng_health_ctrl.sv
`default_nettype none
// trng_health_ctrl: warm-up guard, RCT/APT online health tests, one-entry output stage.
// Revision 1.0
module trng_health_ctrl #(
  parameter int GUARD_CYCLES = 128,
  parameter int REP_CUTOFF   = 4,
  parameter int APT_WINDOW   = 512,
  parameter int APT_CUTOFF   = 13
) (
  input  logic         i_clk,
  input  logic         i_reset,
  trng_health_if.slave bus
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int RW = $clog2(REP_CUTOFF + 1);
  localparam int IW = $clog2(APT_WINDOW);
  localparam int AW = $clog2(APT_CUTOFF + 1);

  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX    = RW'(REP_CUTOFF);
  localparam logic [AW-1:0] APT_MAX    = AW'(APT_CUTOFF);
  localparam logic [IW-1:0] IDX_LAST   = IW'(APT_WINDOW - 1);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    ALARM  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [GW-1:0] guard_cnt;
  logic          hist_valid;
  logic [7:0]    last_byte;
  logic [RW-1:0] rep_cnt;
  logic [IW-1:0] apt_idx;
  logic [7:0]    ref_byte;
  logic [AW-1:0] apt_cnt;
  logic [7:0]    dat_r;
  logic          valid_r;
  logic [1:0]    cause_r;

  logic          take;
  logic          read;
  logic [7:0]    byte_in;
  logic [RW-1:0] rep_new;
  logic [AW-1:0] apt_new;
  logic          rct_fail;
  logic          apt_fail;

  assign byte_in = bus.i_trng_dat;
  assign take    = (state == RUN) && bus.i_trng_valid && (!valid_r || bus.i_ready);

  // Both tests look at history as it stood before this byte.
  always_comb begin
    rep_new = RW'(1);
    if (hist_valid && (byte_in == last_byte))
      rep_new = (rep_cnt == REP_MAX) ? REP_MAX : rep_cnt + RW'(1);
    apt_new = apt_cnt;
    if (apt_idx == '0)
      apt_new = AW'(1);
    else if ((byte_in == ref_byte) && (apt_cnt != APT_MAX))
      apt_new = apt_cnt + AW'(1);
  end

  assign rct_fail = (rep_new == REP_MAX);
  assign apt_fail = (apt_new == APT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= WARMUP;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    read       = 1'b0;
    case (state)
      WARMUP: begin
        read = bus.i_trng_valid;
        if (guard_cnt == GUARD_LAST) state_next = RUN;
      end
      RUN: begin
        read = take;
        if (take && (rct_fail || apt_fail)) state_next = ALARM;
      end
      ALARM: begin
        if (bus.i_clear_alarm) state_next = WARMUP;
      end
      default: state_next = WARMUP;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      guard_cnt  <= '0;
      hist_valid <= 1'b0;
      last_byte  <= '0;
      rep_cnt    <= '0;
      apt_idx    <= '0;
      ref_byte   <= '0;
      apt_cnt    <= '0;
      dat_r      <= '0;
      valid_r    <= 1'b0;
      cause_r    <= '0;
    end else begin
      case (state)
        WARMUP: guard_cnt <= guard_cnt + GW'(1);
        RUN: begin
          if (take) begin
            hist_valid <= 1'b1;
            last_byte  <= byte_in;
            rep_cnt    <= rep_new;
            apt_cnt    <= apt_new;
            if (apt_idx == '0) ref_byte <= byte_in;
            apt_idx <= (apt_idx == IDX_LAST) ? '0 : apt_idx + IW'(1);
            if (rct_fail || apt_fail) begin
              valid_r <= 1'b0;
              cause_r <= {apt_fail, rct_fail};
            end else begin
              dat_r   <= byte_in;
              valid_r <= 1'b1;
            end
          end else if (valid_r && bus.i_ready) begin
            valid_r <= 1'b0;
          end
        end
        ALARM: begin
          if (bus.i_clear_alarm) begin
            guard_cnt  <= '0;
            hist_valid <= 1'b0;
            rep_cnt    <= '0;
            apt_idx    <= '0;
            apt_cnt    <= '0;
            cause_r    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_trng_read  = read;
  assign bus.o_dat        = dat_r;
  assign bus.o_valid      = valid_r;
  assign bus.o_alarm      = (state == ALARM);
  assign bus.o_fail_cause = cause_r;
  assign bus.o_state      = state;
endmodule
`default_nettype wire

// File: tb/tb_trng_health_ctrl.sv
`default_nettype none
// tb_trng_health_ctrl: table vectors, directed corner sequences and random traffic against a queue model.
// Revision 1.0
module tb_trng_health_ctrl;
  localparam int GUARD = 128;
  localparam int REP   = 4;
  localparam int WIN   = 512;
  localparam int APT   = 13;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  trng_health_if ifa ();
  trng_health_if ifb ();

  trng_health_ctrl dut_a (.i_clk(clk), .i_reset(rst_a), .bus(ifa));
  trng_health_ctrl #(.APT_CUTOFF(4)) dut_b (.i_clk(clk), .i_reset(rst_b), .bus(ifb));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state plus raw byte history held in queues.
  int         m_state = 0;
  int         m_guard = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_dat   = 8'h00;
  logic [1:0] m_cause = 2'b00;
  logic [7:0] hist[$];
  logic [7:0] win[$];

  function automatic logic model_read();
    if (m_state == 0) return ifa.i_trng_valid;
    if (m_state == 1) return ifa.i_trng_valid && (!m_valid || ifa.i_ready);
    return 1'b0;
  endfunction

  task automatic compare_a();
    check("read",  int'(ifa.o_trng_read),  int'(model_read()));
    check("valid", int'(ifa.o_valid),      int'(m_valid));
    check("dat",   int'(ifa.o_dat),        int'(m_dat));
    check("alarm", int'(ifa.o_alarm),      int'(m_state == 2));
    check("cause", int'(ifa.o_fail_cause), int'(m_cause));
    check("state", int'(ifa.o_state),      m_state);
  endtask

  task automatic model_step();
    logic       tk;
    logic [7:0] b;
    int         run;
    int         occ;
    logic       rct;
    logic       aptf;
    tk = (m_state == 1) && model_read();
    if (rst_a) begin
      m_state = 0; m_guard = 0; m_valid = 1'b0; m_dat = 8'h00; m_cause = 2'b00;
      hist.delete(); win.delete();
    end else if (m_state == 0) begin
      m_guard++;
      if (m_guard == GUARD) m_state = 1;
    end else if (m_state == 1) begin
      if (tk) begin
        b = ifa.i_trng_dat;
        run = 1;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i] != b) break;
          run++;
        end
        rct = (run == REP);
        hist.push_back(b);
        if (hist.size() > REP) void'(hist.pop_front());
        if (win.size() == WIN) win.delete();
        win.push_back(b);
        occ = 0;
        foreach (win[i]) if (win[i] == win[0]) occ++;
        aptf = (occ == APT);
        if (rct || aptf) begin
          m_state = 2; m_cause = {aptf, rct}; m_valid = 1'b0;
        end else begin
          m_dat = b; m_valid = 1'b1;
        end
      end else if (m_valid && ifa.i_ready) begin
        m_valid = 1'b0;
      end
    end else if (ifa.i_clear_alarm) begin
      m_state = 0; m_guard = 0; m_cause = 2'b00;
      hist.delete(); win.delete();
    end
  endtask

  task automatic sample_a(); @(negedge clk); compare_a(); endtask
  task automatic edge_a();   @(posedge clk); model_step(); #1; endtask
  task automatic tick_a();   sample_a(); edge_a(); endtask

  typedef struct {
    logic       valid;
    logic [7:0] dat;
    logic       ready;
    logic       clear;
    logic       e_read;
    logic       e_valid;
    logic [7:0] e_dat;
    logic       e_dchk;
    logic [1:0] e_state;
    logic [1:0] e_cause;
  } vec_t;
  vec_t rct_tab[7];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] src;
    logic [7:0] exp_fwd;
    logic [7:0] held;
    logic [7:0] d;
    logic       taken;
    int         fwd_cnt;
    int         n33;
    int         n44;
    int         k;

    rct_tab[0] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1, 2'd0};
    rct_tab[1] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 2'd1, 2'd0};
    rct_tab[2] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 2'd1, 2'd0};
    rct_tab[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 2'd1, 2'd0};
    rct_tab[4] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 2'd2, 2'd1};
    rct_tab[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 2'd2, 2'd1};
    rct_tab[6] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 2'd0, 2'd0};

    ifa.i_trng_valid = 1'b0; ifa.i_trng_dat = 8'h00; ifa.i_ready = 1'b1; ifa.i_clear_alarm = 1'b0;
    ifb.i_trng_valid = 1'b0; ifb.i_trng_dat = 8'h00; ifb.i_ready = 1'b1; ifb.i_clear_alarm = 1'b0;

    // Simultaneous RCT and APT trip on DUT B (APT_CUTOFF=4); DUT A held in reset meanwhile.
    @(posedge clk); #1;
    check("b_reset_state", int'(ifb.o_state), 0);
    check("b_reset_valid", int'(ifb.o_valid), 0);
    rst_b = 1'b0;
    repeat (GUARD - 1) begin @(posedge clk); #1; end
    check("b_guard_end_state", int'(ifb.o_state), 0);
    @(posedge clk); #1;
    check("b_run_state", int'(ifb.o_state), 1);
    ifb.i_trng_valid = 1'b1; ifb.i_trng_dat = 8'h77;
    repeat (3) begin @(posedge clk); #1; end
    check("b_third_valid", int'(ifb.o_valid), 1);
    check("b_third_dat", int'(ifb.o_dat), 8'h77);
    @(posedge clk); #1;
    check("b_both_state", int'(ifb.o_state), 2);
    check("b_both_cause", int'(ifb.o_fail_cause), 3);
    check("b_both_valid", int'(ifb.o_valid), 0);
    ifb.i_trng_valid = 1'b0;

    // Reset and warm-up with an incrementing source.
    tick_a();
    check("reset_state", int'(ifa.o_state), 0);
    check("reset_dat", int'(ifa.o_dat), 0);
    check("reset_alarm", int'(ifa.o_alarm), 0);
    rst_a = 1'b0;
    src = 8'h00;
    ifa.i_trng_valid = 1'b1; ifa.i_trng_dat = src; ifa.i_ready = 1'b1;
    for (int c = 0; c < GUARD; c++) begin
      sample_a();
      check("warmup_read", int'(ifa.o_trng_read), 1);
      check("warmup_valid", int'(ifa.o_valid), 0);
      taken = ifa.o_trng_read;
      edge_a();
      if (taken) src++;
      ifa.i_trng_dat = src;
    end
    check("run_entry", int'(ifa.o_state), 1);

    exp_fwd = src;
    fwd_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      ifa.i_ready = !(c >= 30 && c < 35);
      sample_a();
      if (!ifa.i_ready) begin
        if (c == 30) held = ifa.o_dat;
        check("stall_read", int'(ifa.o_trng_read), 0);
        check("stall_hold", int'(ifa.o_dat), int'(held));
      end else if (ifa.o_valid) begin
        check("fwd_order", int'(ifa.o_dat), int'(exp_fwd));
        exp_fwd++;
        fwd_cnt++;
      end
      taken = ifa.o_trng_read;
      edge_a();
      if (taken) src++;
      ifa.i_trng_dat = src;
    end
    check("fwd_count", fwd_cnt, 39);

    // RCT trip and clear via the vector table.
    ifa.i_trng_valid = 1'b0; ifa.i_ready = 1'b1;
    tick_a();
    foreach (rct_tab[i]) begin
      ifa.i_trng_valid  = rct_tab[i].valid;
      ifa.i_trng_dat    = rct_tab[i].dat;
      ifa.i_ready       = rct_tab[i].ready;
      ifa.i_clear_alarm = rct_tab[i].clear;
      sample_a();
      check("tab_read", int'(ifa.o_trng_read), int'(rct_tab[i].e_read));
      check("tab_valid", int'(ifa.o_valid), int'(rct_tab[i].e_valid));
      if (rct_tab[i].e_dchk) check("tab_dat", int'(ifa.o_dat), int'(rct_tab[i].e_dat));
      check("tab_state", int'(ifa.o_state), int'(rct_tab[i].e_state));
      check("tab_cause", int'(ifa.o_fail_cause), int'(rct_tab[i].e_cause));
      edge_a();
    end
    ifa.i_trng_valid = 1'b0; ifa.i_clear_alarm = 1'b0;
    repeat (GUARD - 2) tick_a();
    check("guard_after_clear_wait", int'(ifa.o_state), 0);
    tick_a();
    check("guard_after_clear_run", int'(ifa.o_state), 1);

    // APT: 13th non-consecutive 0x33 in one window.
    k = 0; n33 = 0;
    ifa.i_trng_valid = 1'b1; ifa.i_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ifa.o_state != 2'd1) break;
      if (i % 2 == 0) d = 8'h33;
      else begin d = 8'h80 + 8'(k % 64); k++; end
      ifa.i_trng_dat = d;
      tick_a();
      if (d == 8'h33) n33++;
    end
    check("apt_trip_state", int'(ifa.o_state), 2);
    check("apt_trip_cause", int'(ifa.o_fail_cause), 2);
    check("apt_trip_count", n33, 13);

    ifa.i_trng_valid = 1'b0; ifa.i_clear_alarm = 1'b1;
    tick_a();
    ifa.i_clear_alarm = 1'b0;
    repeat (GUARD) tick_a();
    check("apt_rerun", int'(ifa.o_state), 1);

    // 12 occurrences across a full window, then a new reference 0x44.
    ifa.i_trng_valid = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      if (i < 24 && i % 2 == 0) d = 8'h33;
      else begin d = 8'h80 + 8'(k % 64); k++; end
      ifa.i_trng_dat = d;
      tick_a();
    end
    check("apt_12_no_alarm", int'(ifa.o_state), 1);
    n33 = 0; n44 = 0;
    for (int i = 0; i < 80; i++) begin
      if (ifa.o_state != 2'd1) break;
      case (i % 4)
        0:       d = 8'h44;
        2:       begin d = 8'h80 + 8'(k % 64); k++; end
        default: d = 8'h33;
      endcase
      ifa.i_trng_dat = d;
      tick_a();
      if (d == 8'h44) n44++;
      if (d == 8'h33) n33++;
    end
    check("apt_new_ref_cause", int'(ifa.o_fail_cause), 2);
    check("apt_new_ref_count", n44, 13);
    check("apt_old_ref_ignored", n33, 24);

    // Reset while a byte is pending.
    ifa.i_trng_valid = 1'b0; ifa.i_clear_alarm = 1'b1;
    tick_a();
    ifa.i_clear_alarm = 1'b0;
    repeat (GUARD) tick_a();
    ifa.i_trng_valid = 1'b1; ifa.i_trng_dat = 8'h10;
    tick_a();
    ifa.i_trng_dat = 8'h11;
    tick_a();
    check("pre_reset_valid", int'(ifa.o_valid), 1);
    rst_a = 1'b1;
    tick_a();
    rst_a = 1'b0;
    sample_a();
    check("post_reset_valid", int'(ifa.o_valid), 0);
    check("post_reset_state", int'(ifa.o_state), 0);
    edge_a();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      ifa.i_trng_valid  = ($urandom % 4) != 0;
      ifa.i_ready       = ($urandom % 3) != 0;
      ifa.i_trng_dat    = ($urandom % 2) ? 8'($urandom % 4) : 8'($urandom);
      ifa.i_clear_alarm = ($urandom % 8) == 0;
      rst_a             = ($urandom % 700) == 0;
      tick_a();
    end
    rst_a = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/trng_health_ctrl.md
Name: trng_health_ctrl

Overview:
Sequencing and health-monitoring controller between lfsr_trng and trng_com. After reset it holds a warm-up guard period and discards all entropy bytes during it. It then forwards bytes through a one-entry output register to the serial link. Every forwarded byte is checked by an online repetition-count test (RCT) and an adaptive-proportion test (APT); a failure latches an alarm and halts output until software clears it.

Parameters:
GUARD_CYCLES, 128, warm-up cycles after reset/clear during which bytes are read and dropped (>=1)
REP_CUTOFF, 4, consecutive identical bytes that trip the RCT (>=2)
APT_WINDOW, 512, bytes per APT window (power of two, >=2)
APT_CUTOFF, 13, occurrences of the window reference byte that trip the APT (2..APT_WINDOW)

Ports:
i_clk  in  1  clock
i_reset  in  1  reset; one clock, synchronous, active-high
i_trng_valid  in  1  source byte available
i_trng_dat  in  8  source byte
o_trng_read  out  1  combinational consume strobe to source
o_dat  out  8  forwarded byte
o_valid  out  1  o_dat valid
i_ready  in  1  sink accepts o_dat this cycle
i_clear_alarm  in  1  leave ALARM, restart warm-up
o_alarm  out  1  high in ALARM
o_fail_cause  out  2  bit0 RCT, bit1 APT; latched at alarm entry
o_state  out  2  0 WARMUP, 1 RUN, 2 ALARM

Behaviour:
- Reset: state WARMUP, guard_cnt=0, o_dat=0, o_valid=0, o_alarm=0, o_fail_cause=0, RCT/APT history cleared (hist_valid=0, rep_cnt=0, apt_idx=0, apt_cnt=0).
- WARMUP:
  - o_trng_read = i_trng_valid; consumed bytes are dropped and not tested.
  - guard_cnt increments every cycle.
  - When guard_cnt==GUARD_CYCLES-1, the next state is RUN, entered exactly GUARD_CYCLES cycles after reset deasserts.
  - o_valid=0 throughout.
- RUN:
  - o_trng_read = i_trng_valid & (~o_valid | i_ready), combinational; a "take" is o_trng_read=1.
  - On a take the byte b is tested in the same cycle, using history before the update.
  - RCT:
    - new_rep = (hist_valid & b==last) ? rep_cnt+1 : 1.
    - Fail if new_rep==REP_CUTOFF.
    - Update last=b, hist_valid=1; rep_cnt saturates at REP_CUTOFF.
  - APT:
    - If apt_idx==0: ref=b, apt_cnt=1.
    - Otherwise, if b==ref: apt_cnt+1.
    - Fail if the new apt_cnt==APT_CUTOFF.
    - apt_idx increments and wraps from APT_WINDOW-1 to 0.
  - No failure: o_dat<=b, o_valid<=1 next cycle (latency 1). With i_ready held high, throughput is 1 byte/cycle.
  - Failure (either or both tests): byte not forwarded; next state ALARM; o_fail_cause<={apt_fail,rct_fail}; o_valid<=0 (a pending byte is discarded).
  - No take: o_valid & i_ready clears o_valid; o_dat holds its last value.
- ALARM:
  - o_trng_read=0, o_valid=0, o_alarm=1.
  - o_fail_cause is held; o_dat holds its value.
  - i_clear_alarm=1: next state WARMUP, guard_cnt=0, all history cleared, o_fail_cause=0.
  - i_clear_alarm is ignored in WARMUP and RUN.
- Simultaneous i_reset with anything: reset wins. Reset mid-RUN drops the pending byte.
- Counter widths: guard $clog2(GUARD_CYCLES+1); apt_idx $clog2(APT_WINDOW); apt_cnt and rep_cnt wide enough for their cutoffs. No overflow is permitted; counters saturate or wrap only as stated above.
- o_alarm = (state==ALARM); o_state is driven from the state register.

Test Plan:
1. Reset, then i_trng_valid=1 with an incrementing byte source, i_ready=1 -> o_trng_read=1 for 128 cycles with o_valid=0; o_state=1 at cycle 128; first forwarded byte appears 1 cycle after its take; one new byte per cycle, no duplicates or drops.
2. In RUN, i_ready low for 5 cycles while source valid -> o_valid=1, o_dat stable, o_trng_read=0; when i_ready rises, the next byte follows with no loss.
3. Source bytes 0x5A,0x5A,0x5A,0x5A -> first three forwarded; the fourth take enters ALARM, o_fail_cause=2'b01, o_valid=0, o_trng_read=0.
4. APT window with reference 0x33 repeated non-consecutively (0x33,x,0x33,x,...), 13th occurrence within 512 bytes -> ALARM, o_fail_cause=2'b10. The same pattern with only 12 occurrences, plus a window wrap -> no alarm, and the new window picks a new reference.
5. Byte that trips RCT and APT simultaneously (APT_CUTOFF=4 override, four equal bytes opening a window) -> o_fail_cause=2'b11.
6. ALARM, then pulse i_clear_alarm -> o_state=0, o_alarm=0, o_fail_cause=0, and a full 128-cycle guard before RUN. Additionally, assert i_reset mid-RUN with o_valid=1 -> o_valid=0 the next cycle and o_state=0.
